// File: rtl/svm_pkg.sv
// Shared definitions for the SVM decision unit: default sizes, score/coef types
// and the saturating helpers used by the datapath.
package svm_pkg;

  localparam int DEF_ACCUM_SIZE = 64;
  localparam int DEF_COEF_SIZE  = 32;
  localparam int DEF_FRAC_BITS  = 16;
  localparam int DEF_NUM_SV     = 10;
  localparam int DEF_FIFO_DEPTH = 2;

  // Working width for saturation: wide enough for a full ACCUM x ACCUM square
  // plus headroom, so every intermediate fits before it is clamped.
  localparam int SAT_W = 192;

  typedef logic signed [DEF_ACCUM_SIZE-1:0] score_t;
  typedef logic signed [DEF_COEF_SIZE-1:0]  coef_t;
  typedef logic signed [SAT_W-1:0]          wide_t;

  // Clamp a wide signed value into the signed range of a w-bit number.
  function automatic wide_t sat_trunc(input wide_t x, input int unsigned w);
    wide_t hi;
    wide_t lo;
    hi = wide_t'((SAT_W'(1) << (w - 1)) - SAT_W'(1));
    lo = ~hi;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Add two wide signed values and clamp the sum into w bits.
  function automatic wide_t sat_add(input wide_t a, input wide_t b, input int unsigned w);
    return sat_trunc(a + b, w);
  endfunction

endpackage

// File: rtl/svm_decision_unit_if.sv
// Bus bundle of the SVM decision unit: dot-product stream in, coefficient and
// bias configuration, score stream out. slave = the decision unit.
interface svm_decision_unit_if #(
  parameter int ACCUM_SIZE = 64,
  parameter int COEF_SIZE  = 32,
  parameter int NUM_SV     = 10
);
  localparam int IDX_W = $clog2(NUM_SV);

  logic                         dp_valid;
  logic signed [ACCUM_SIZE-1:0] dp_data;
  logic                         dp_ready;
  logic                         coef_we;
  logic [IDX_W-1:0]             coef_addr;
  logic signed [COEF_SIZE-1:0]  coef_data;
  logic                         bias_we;
  logic signed [ACCUM_SIZE-1:0] bias_data;
  logic                         out_valid;
  logic                         out_ready;
  logic signed [ACCUM_SIZE-1:0] out_score;
  logic                         out_label;
  logic                         cfg_err;

  modport master (
    output dp_valid, dp_data, coef_we, coef_addr, coef_data, bias_we, bias_data, out_ready,
    input  dp_ready, out_valid, out_score, out_label, cfg_err
  );

  modport slave (
    input  dp_valid, dp_data, coef_we, coef_addr, coef_data, bias_we, bias_data, out_ready,
    output dp_ready, out_valid, out_score, out_label, cfg_err
  );

endinterface

// File: rtl/svm_result_fifo.sv
// Small synchronous result FIFO of {score, label}. The occupancy count is
// exported so the upstream credit check can hold off an instance's final beat.
module svm_result_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         i_push,
  input  logic signed [W-1:0]          i_score,
  input  logic                         i_label,
  input  logic                         i_pop,
  output logic                         o_valid,
  output logic signed [W-1:0]          o_score,
  output logic                         o_label,
  output logic [$clog2(DEPTH+1)-1:0]   o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic signed [W-1:0] r_score_mem [DEPTH];
  logic                r_label_mem [DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr;
  logic [PTR_W-1:0]    r_rd_ptr;
  logic [CNT_W-1:0]    r_count;
  logic                w_pop;
  logic                w_push;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop  = i_pop && (r_count != '0);
  assign w_push = i_push && ((r_count != FULL_CNT) || w_pop);

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage; contents are only observable through a valid head.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_score_mem[r_wr_ptr] <= i_score;
      r_label_mem[r_wr_ptr] <= i_label;
    end
  end

  assign o_valid = (r_count != '0);
  assign o_score = o_valid ? r_score_mem[r_rd_ptr] : '0;
  assign o_label = o_valid & r_label_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/svm_decision_unit.sv
// SVM decision unit: weights each incoming support-vector dot product by its
// alpha*y coefficient, accumulates with saturation, adds the bias and queues a
// signed score plus class label. Define SVM_POLY2_KERNEL_EN to square each dot
// product (degree-2 polynomial kernel) before weighting; otherwise linear.
module svm_decision_unit
  import svm_pkg::*;
#(
  parameter int ACCUM_SIZE = DEF_ACCUM_SIZE,
  parameter int COEF_SIZE  = DEF_COEF_SIZE,
  parameter int FRAC_BITS  = DEF_FRAC_BITS,
  parameter int NUM_SV     = DEF_NUM_SV,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input logic               clk,
  input logic               rst_n,
  svm_decision_unit_if.slave bus
);

  localparam int IDX_W  = $clog2(NUM_SV);
  localparam int PROD_W = ACCUM_SIZE + COEF_SIZE;
  localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SV - 1);

  function automatic wide_t widen_acc(input logic signed [ACCUM_SIZE-1:0] v);
    return $signed({{(SAT_W-ACCUM_SIZE){v[ACCUM_SIZE-1]}}, v});
  endfunction

  function automatic wide_t widen_prod(input logic signed [PROD_W-1:0] v);
    return $signed({{(SAT_W-PROD_W){v[PROD_W-1]}}, v});
  endfunction

  // Clamp a wide intermediate into the accumulator range.
  function automatic logic signed [ACCUM_SIZE-1:0] sat_acc(input wide_t v);
    return ACCUM_SIZE'(sat_trunc(v, ACCUM_SIZE));
  endfunction

  // Saturating add of two accumulator-width values.
  function automatic logic signed [ACCUM_SIZE-1:0] sat_sum(input logic signed [ACCUM_SIZE-1:0] a,
                                                           input logic signed [ACCUM_SIZE-1:0] b);
    return sat_acc(sat_add(widen_acc(a), widen_acc(b), ACCUM_SIZE));
  endfunction

  logic [IDX_W-1:0]             r_sv_idx;
  logic signed [COEF_SIZE-1:0]  r_coef [NUM_SV];
  logic signed [ACCUM_SIZE-1:0] r_bias;
  logic                         r_cfg_err;

  logic                         r_vld_p1;
  logic                         r_first_p1;
  logic                         r_last_p1;
  logic signed [ACCUM_SIZE-1:0] r_term_p1;
  logic                         r_fin_p2;
  logic signed [ACCUM_SIZE-1:0] r_acc_p2;

  logic                         w_dp_ready;
  logic                         w_beat;
  logic signed [ACCUM_SIZE-1:0] w_kern;
  logic signed [COEF_SIZE-1:0]  w_coef;
  logic signed [PROD_W-1:0]     w_prod;
  logic signed [ACCUM_SIZE-1:0] w_term;
  logic                         w_fin_p1;
  logic [CNT_W-1:0]             w_fifo_count;
  logic [CNT_W+1:0]             w_used;
  logic                         w_idle;
  logic                         w_addr_ok;
  logic signed [ACCUM_SIZE-1:0] w_score_p3;

  // ---- stage 1: kernel and coefficient weighting ----
`ifdef SVM_POLY2_KERNEL_EN
  logic signed [2*ACCUM_SIZE-1:0] w_sq;
  assign w_sq   = bus.dp_data * bus.dp_data;
  assign w_kern = sat_acc($signed({{(SAT_W-2*ACCUM_SIZE){w_sq[2*ACCUM_SIZE-1]}}, w_sq}) >>> FRAC_BITS);
`else
  assign w_kern = bus.dp_data;
`endif

  assign w_coef = r_coef[r_sv_idx];
  assign w_prod = w_kern * w_coef;
  assign w_term = sat_acc(widen_prod(w_prod) >>> FRAC_BITS);

  // Credit check: only the final beat of an instance can stall, and only when
  // every FIFO slot is taken or already promised to a finish in flight.
  assign w_fin_p1   = r_vld_p1 & r_last_p1;
  assign w_used     = (CNT_W+2)'(w_fifo_count) + (CNT_W+2)'(w_fin_p1) + (CNT_W+2)'(r_fin_p2);
  assign w_dp_ready = !((r_sv_idx == LAST_IDX) && (w_used >= (CNT_W+2)'(FIFO_DEPTH)));
  assign w_beat     = bus.dp_valid && w_dp_ready;

  // Configuration may only change between instances with nothing in flight.
  assign w_idle    = (r_sv_idx == '0) && !r_vld_p1 && !r_fin_p2;
  assign w_addr_ok = (int'(bus.coef_addr) < NUM_SV);

  // Beat position tracking and pipeline valids; accumulator first/continue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sv_idx <= '0;
      r_vld_p1 <= 1'b0;
      r_fin_p2 <= 1'b0;
      r_acc_p2 <= '0;
    end else begin
      if (w_beat) r_sv_idx <= (r_sv_idx == LAST_IDX) ? '0 : r_sv_idx + 1'b1;
      r_vld_p1 <= w_beat;
      // ---- stage 2: accumulate ----
      r_fin_p2 <= w_fin_p1;
      if (r_vld_p1) r_acc_p2 <= r_first_p1 ? r_term_p1 : sat_sum(r_acc_p2, r_term_p1);
    end
  end

  // Stage-1 data registers; qualified by r_vld_p1 so they need no reset.
  always_ff @(posedge clk) begin
    if (w_beat) begin
      r_term_p1  <= w_term;
      r_first_p1 <= (r_sv_idx == '0);
      r_last_p1  <= (r_sv_idx == LAST_IDX);
    end
  end

  // Coefficient/bias writes when idle; a write while busy is dropped and flagged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_SV; i++) r_coef[i] <= '0;
      r_bias    <= '0;
      r_cfg_err <= 1'b0;
    end else begin
      if (bus.coef_we) begin
        if (!w_idle)        r_cfg_err <= 1'b1;
        else if (w_addr_ok) r_coef[bus.coef_addr] <= bus.coef_data;
      end
      if (bus.bias_we) begin
        if (!w_idle) r_cfg_err <= 1'b1;
        else         r_bias    <= bus.bias_data;
      end
    end
  end

  // ---- stage 3: bias and enqueue ----
  assign w_score_p3 = sat_sum(r_acc_p2, r_bias);

  svm_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (ACCUM_SIZE)
  ) u_result_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_fin_p2),
    .i_score (w_score_p3),
    .i_label (~w_score_p3[ACCUM_SIZE-1]),
    .i_pop   (bus.out_ready),
    .o_valid (bus.out_valid),
    .o_score (bus.out_score),
    .o_label (bus.out_label),
    .o_count (w_fifo_count)
  );

  assign bus.dp_ready = w_dp_ready;
  assign bus.cfg_err  = r_cfg_err;

endmodule

// File: doc/svm_decision_unit.md
# svm_decision_unit

Downstream consumer of the systolic dot-product array. It takes the per-support-vector dot-product stream for each test instance, optionally applies a polynomial kernel, weights each term by a programmable coefficient (alpha·y), sums the terms with saturation, adds a bias and emits a signed score and a class label. A small result FIFO decouples the array from the output consumer, so back-pressure reaches the array only on an instance's final beat.

## Interface
- ACCUM_SIZE, 64, width of incoming dot products, terms, accumulator and score (signed)
- COEF_SIZE, 32, signed coefficient width, fixed point with FRAC_BITS fraction bits
- FRAC_BITS, 16, fraction bits of coefficients and kernel output
- NUM_SV, 10, dot products per test instance (must be ≥2)
- FIFO_DEPTH, 2, result FIFO entries
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- dp_valid  in  1  dot-product beat valid
- dp_data  in  ACCUM_SIZE  signed dot product, SV order 0..NUM_SV-1
- dp_ready  out  1  beat accepted when dp_valid && dp_ready
- coef_we  in  1  coefficient write strobe
- coef_addr  in  $clog2(NUM_SV)  coefficient index
- coef_data  in  COEF_SIZE  signed alpha·y
- bias_we  in  1  bias write strobe
- bias_data  in  ACCUM_SIZE  signed bias
- out_valid  out  1  FIFO head valid
- out_ready  in  1  head popped when out_valid && out_ready
- out_score  out  ACCUM_SIZE  signed decision value
- out_label  out  1  1 when out_score ≥ 0
- cfg_err  out  1  sticky: config write rejected

## Operation
- sv_idx counter tracks position in instance; increments per accepted beat, wraps NUM_SV-1 → 0.
- Stage 1 (term): k = kernel(dp_data); term = sat((k · coef[sv_idx]) >>> FRAC_BITS); product is full ACCUM_SIZE+COEF_SIZE bits, arithmetic shift, clamp to [−2^(ACCUM_SIZE−1), 2^(ACCUM_SIZE−1)−1].
- Stage 2 (accumulate): acc = sat(acc + term); on first term of instance acc = term (no clear cycle needed).
- Stage 3 (finish): on last term, score = sat(acc + bias) written to FIFO.
- Back-pressure: dp_ready = 1 unless sv_idx == NUM_SV-1 and (FIFO count + finishes in flight) ≥ FIFO_DEPTH. Non-final beats never stall.
- Output: out_score/out_label driven from FIFO head; pop on handshake; order preserved. out_valid independent of out_ready.
- Config: coef_we/bias_we take effect only when idle (sv_idx == 0 and stages 1–2 empty); otherwise write ignored, cfg_err set. cfg_err cleared only by reset.
- Simultaneous push and pop on full FIFO: both occur, count unchanged.

## Timing
- Reset: dp_ready 1, out_valid 0, out_score 0, out_label 0, cfg_err 0; sv_idx 0, acc 0, FIFO empty, coefficients 0, bias 0, pipeline valids 0.
- Final beat accepted at edge n: term registered at n, acc at n+1, FIFO write at n+2; out_valid high in cycle after edge n+2 (3-cycle latency).
- Throughput: one beat per cycle; back-to-back instances with no bubble while FIFO has space.
- Config write accepted at edge m is used by any beat accepted at edge ≥ m+1.
- Reset mid-instance: partial sum discarded, next beat after reset is SV 0.

## Configuration
- SVM_POLY2_KERNEL_EN defined: kernel(x) = sat((x·x) >>> FRAC_BITS) (degree-2 polynomial, x treated as FRAC_BITS fixed point); adds one multiplier, latency unchanged.
- Undefined: kernel(x) = x (linear).

## Structure
- svm_pkg: ACCUM_SIZE/COEF_SIZE/FRAC_BITS defaults, score_t and coef_t typedefs, sat_trunc() saturating narrow function, sat_add() function.
- Sub-module svm_result_fifo: FIFO_DEPTH-entry synchronous FIFO of {score, label} with count output used for the credit check.

## Test plan
- Coefs all 0x10000 (1.0), bias 0, ten beats dp=5 → out_score 50, out_label 1, out_valid 3 cycles after last beat.
- Coefs all 0xFFFF0000 (−1.0), bias 20, ten beats dp=3 → out_score −10, out_label 0.
- out_ready held 0, three instances streamed → two FIFO entries, dp_ready 0 on instance 3 beat 10; release out_ready → scores popped in order, beat accepted.
- dp=0x7FFF_FFFF_FFFF_FFFF, coef 0x20000 → terms and score saturate at 0x7FFF_FFFF_FFFF_FFFF, no wrap; label 1.
- rst_n asserted after 4 beats, then ten beats dp=1, coef 1.0 → out_score 10; coef_we mid-instance → coef unchanged, cfg_err 1.
- With SVM_POLY2_KERNEL_EN: coef 1.0, bias 0, ten beats dp=0x20000 → out_score 0x280000.
